lo_quad_gen: RTL
================

Name: lo_quad_gen

Overview:
- Digital local-oscillator generator that sits directly upstream of the single-balanced mixer and drives its LO input pin.
- Divides the system clock down to a programmable frequency and produces two square waves, I and Q, 90 degrees apart, with 50% duty.
- Divider ratio, enable and sideband swap are configured through a 3-wire serial port on dedicated input pins.
- Frequency changes are glitch-free and take effect only at quarter-period boundaries.

Parameters:
- DIV_W, 16, width of the quarter-period divider register.
- DIV_RESET, 3, divider value loaded on reset.
- SYNC_STAGES, 2, flip-flop stages in each serial-pin synchronizer (minimum 2).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- sck  input  1  serial clock; asynchronous to clk.
- sdi  input  1  serial data, MSB first, sampled on rising sck.
- cs_n  input  1  serial frame select, active low.
- lo_i  output  1  in-phase LO; feeds the mixer LO pin.
- lo_q  output  1  quadrature LO.
- lo_en  output  1  current enable bit.
- frame_err  output  1  one-cycle pulse when a frame is rejected.

Behaviour:
- Reset values:
  - div_shadow = div_active = DIV_RESET.
  - enable = 0, swap = 0.
  - Quarter counter = 0, Johnson state = 2'b00.
  - All outputs = 0.
  - Serial shift register and bit count cleared.
- Synchronizers:
  - sck, sdi and cs_n each pass through SYNC_STAGES flip-flops.
  - Rising sck and rising cs_n are detected from the synchronized value against its one-cycle-delayed copy.
  - sck must be at most clk/6.
- Serial frame:
  - While synced cs_n = 0, each rising sck shifts sdi into a 24-bit shift register. The bit count saturates at 25.
  - On rising cs_n the frame is checked. A valid frame has bit count exactly 24.
  - Command 0x01: div_shadow <= data[DIV_W-1:0].
  - Command 0x02: enable <= data[0], swap <= data[1].
  - A frame with wrong bit count or any other command is discarded, and frame_err pulses on the next cycle.
  - Bit count clears on every rising cs_n and whenever cs_n is high.
  - Registers update on the cycle after rising cs_n is detected.
- LO core, active only while enable = 1:
  - The quarter counter increments every clk.
  - When counter == div_active: counter <= 0, Johnson state advances 00 -> 01 -> 11 -> 10 -> 00, and div_active <= div_shadow.
  - Quarter period = div_active + 1 clocks; LO period = 4 * (div_active + 1).
  - div = 0 gives period 4 clocks.
  - A divider write mid-quarter never shortens or extends the quarter in progress.
- Outputs, all registered:
  - swap = 0: lo_i = state[1], lo_q = state[0], so Q leads I.
  - swap = 1: outputs exchanged (opposite sideband).
  - A swap change applies immediately and may produce one shortened pulse. This is accepted.
- Disable:
  - On the cycle enable becomes 0: counter <= 0, state <= 00, div_active <= div_shadow.
  - lo_i and lo_q are 0 from the next cycle and held at 0.
- Enable:
  - Outputs start from 00.
  - First edge (of lo_q when swap = 0) occurs div_active + 1 clocks after the enable register sets.
- rst mid-frame or mid-period returns everything to the reset values. Partially shifted bits are lost.
- lo_en = enable register.

Decomposition:
- Shared package:
  - CMD_DIV = 8'h01, CMD_CTRL = 8'h02.
  - FRAME_BITS = 24.
  - Johnson state encoding constants.
- One sub-module, lo_serial_cfg: synchronizers, edge detect, shift register, frame check and config registers.
- The top module holds the divider, Johnson counter and output muxing.

Test Plan:
- Reset, then frame {0x02, 0x0001} -> lo_en = 1, lo_i/lo_q period 16 clk (DIV_RESET = 3), Q rising 4 clk before I rising.
- Frame {0x01, 0x0009} while running -> current quarter completes at old length, then period 40 clk, no pulse shorter than 4 or 10 clk.
- 23-bit frame; then 25-bit frame; then command 0x07 -> frame_err pulses each time (3 pulses), divider and enable unchanged.
- Frame {0x02, 0x0003} -> swap = 1, I now leads Q by 90 degrees at the same period.
- Divider 0x0000 and enable -> lo_i pattern 0,0,1,1 repeating every 4 clk; then frame {0x02, 0x0000} -> both outputs 0 one cycle after lo_en falls.
- rst asserted mid-frame after 12 bits and mid-period -> all outputs 0; the next complete valid frame is accepted normally.

Source files
------------

// File: rtl/lo_quad_gen_pkg.sv
// Shared definitions for the quadrature LO generator: serial command codes,
// frame geometry, Johnson-counter state encoding and its successor function.
package lo_quad_gen_pkg;

  // Serial command codes carried in the top byte of a frame.
  localparam logic [7:0] CMD_DIV  = 8'h01;
  localparam logic [7:0] CMD_CTRL = 8'h02;

  // Bit counter is wide enough to hold the saturation value.
  localparam int CNT_W = 5;

  // A frame is exactly 24 bits; the counter sticks at 25 so overruns stay
  // distinguishable from a good frame.
  localparam logic [CNT_W-1:0] FRAME_BITS  = 5'd24;
  localparam logic [CNT_W-1:0] BIT_CNT_SAT = 5'd25;

  // Four-phase Johnson sequence: 00 -> 01 -> 11 -> 10 -> 00.
  // Only one bit changes per quarter, so I and Q never glitch together.
  typedef enum logic [1:0] {
    JS_00 = 2'b00,
    JS_01 = 2'b01,
    JS_11 = 2'b11,
    JS_10 = 2'b10
  } johnson_t;

  // Layout of a received frame, MSB first on the wire.
  typedef struct packed {
    logic [7:0]  cmd;
    logic [15:0] data;
  } frame_t;

  // Successor state of the Johnson counter.
  function automatic johnson_t johnson_next(input johnson_t cur);
    johnson_t nxt;
    case (cur)
      JS_00:   nxt = JS_01;
      JS_01:   nxt = JS_11;
      JS_11:   nxt = JS_10;
      JS_10:   nxt = JS_00;
      default: nxt = JS_00;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/lo_quad_gen_if.sv
// 3-wire serial configuration port of the LO generator. The controller
// drives all three pins; the generator only listens.
interface lo_quad_gen_if;
  logic sck;
  logic sdi;
  logic cs_n;

  modport master (output sck, output sdi, output cs_n);
  modport slave  (input  sck, input  sdi, input  cs_n);
endinterface

// File: rtl/lo_serial_cfg.sv
// Serial configuration receiver: synchronizes the asynchronous serial pins,
// shifts in 24-bit frames, validates them on frame close and holds the
// divider/enable/swap configuration registers.
module lo_serial_cfg
  import lo_quad_gen_pkg::*;
#(
  parameter int          DIV_W       = 16,
  parameter int unsigned DIV_RESET   = 32'd3,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  lo_quad_gen_if.slave     spi,
  output logic [DIV_W-1:0] div_shadow,
  output logic             enable,
  output logic             swap,
  output logic             frame_err
);

  // Never fewer than two stages, whatever the caller asks for.
  localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [SS-1:0]    sck_sync_r;
  logic [SS-1:0]    sdi_sync_r;
  logic [SS-1:0]    cs_sync_r;
  logic             sck_d_r;
  logic             cs_d_r;
  logic [23:0]      shift_r;
  logic [CNT_W-1:0] bit_cnt_r;
  logic [DIV_W-1:0] div_shadow_r;
  logic             enable_r;
  logic             swap_r;
  logic             frame_err_r;

  logic   sck_s;
  logic   sdi_s;
  logic   cs_s;
  logic   sck_rise_s;
  logic   cs_rise_s;
  logic   len_ok_s;
  logic   cmd_div_s;
  logic   cmd_ctrl_s;
  logic   frame_bad_s;
  frame_t frame_s;

  assign sck_s = sck_sync_r[SS-1];
  assign sdi_s = sdi_sync_r[SS-1];
  assign cs_s  = cs_sync_r[SS-1];

  // Pin synchronizers plus one-cycle-delayed copies for edge detection;
  // cs_n resets to its idle-high level so reset never looks like a frame end.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync_r <= '0;
      sdi_sync_r <= '0;
      cs_sync_r  <= '1;
      sck_d_r    <= 1'b0;
      cs_d_r     <= 1'b1;
    end else begin
      sck_sync_r <= {sck_sync_r[SS-2:0], spi.sck};
      sdi_sync_r <= {sdi_sync_r[SS-2:0], spi.sdi};
      cs_sync_r  <= {cs_sync_r[SS-2:0], spi.cs_n};
      sck_d_r    <= sck_s;
      cs_d_r     <= cs_s;
    end
  end

  // Edge detection and frame decode on the synchronized pin values.
  always_comb begin
    sck_rise_s  = sck_s & ~sck_d_r;
    cs_rise_s   = cs_s & ~cs_d_r;
    frame_s     = frame_t'(shift_r);
    len_ok_s    = (bit_cnt_r == FRAME_BITS);
    cmd_div_s   = cs_rise_s & len_ok_s & (frame_s.cmd == CMD_DIV);
    cmd_ctrl_s  = cs_rise_s & len_ok_s & (frame_s.cmd == CMD_CTRL);
    frame_bad_s = cs_rise_s & ~(cmd_div_s | cmd_ctrl_s);
  end

  // Shift register and saturating bit count; the count is held at zero
  // whenever the frame is not selected, which also covers the closing edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_r   <= '0;
      bit_cnt_r <= '0;
    end else if (cs_s) begin
      shift_r   <= shift_r;
      bit_cnt_r <= '0;
    end else if (sck_rise_s) begin
      shift_r <= {shift_r[22:0], sdi_s};
      if (bit_cnt_r != BIT_CNT_SAT) begin
        bit_cnt_r <= bit_cnt_r + 5'd1;
      end else begin
        bit_cnt_r <= bit_cnt_r;
      end
    end else begin
      shift_r   <= shift_r;
      bit_cnt_r <= bit_cnt_r;
    end
  end

  // Configuration registers and reject pulse, updated the cycle after the
  // frame-close edge is seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_shadow_r <= DIV_W'(DIV_RESET);
      enable_r     <= 1'b0;
      swap_r       <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      frame_err_r <= frame_bad_s;
      if (cmd_div_s) begin
        div_shadow_r <= DIV_W'(frame_s.data);
      end else begin
        div_shadow_r <= div_shadow_r;
      end
      if (cmd_ctrl_s) begin
        enable_r <= frame_s.data[0];
        swap_r   <= frame_s.data[1];
      end else begin
        enable_r <= enable_r;
        swap_r   <= swap_r;
      end
    end
  end

  assign div_shadow = div_shadow_r;
  assign enable     = enable_r;
  assign swap       = swap_r;
  assign frame_err  = frame_err_r;

endmodule

// File: rtl/lo_quad_gen.sv
// Quadrature local-oscillator generator. A quarter-period counter clocks a
// two-bit Johnson counter whose bits become the I and Q square waves.
// The divider is only reloaded at a quarter boundary, so frequency changes
// never produce a runt or stretched quarter.
module lo_quad_gen
  import lo_quad_gen_pkg::*;
#(
  parameter int          DIV_W       = 16,
  parameter int unsigned DIV_RESET   = 32'd3,
  parameter int          SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  lo_quad_gen_if.slave spi,
  output logic         lo_i,
  output logic         lo_q,
  output logic         lo_en,
  output logic         frame_err
);

  logic [DIV_W-1:0] div_shadow_s;
  logic             enable_s;
  logic             swap_s;

  logic [DIV_W-1:0] cnt_r;
  logic [DIV_W-1:0] div_active_r;
  johnson_t         state_r;
  logic             lo_i_r;
  logic             lo_q_r;

  logic [DIV_W-1:0] cnt_nxt_s;
  logic [DIV_W-1:0] div_nxt_s;
  johnson_t         state_nxt_s;
  logic [1:0]       state_bits_s;
  logic             lo_i_nxt_s;
  logic             lo_q_nxt_s;

  lo_serial_cfg #(
    .DIV_W       (DIV_W),
    .DIV_RESET   (DIV_RESET),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_cfg (
    .clk        (clk),
    .rst        (rst),
    .spi        (spi),
    .div_shadow (div_shadow_s),
    .enable     (enable_s),
    .swap       (swap_s),
    .frame_err  (frame_err)
  );

  // Quarter counter and Johnson next state; while disabled everything is
  // parked at phase 00 with the latest divider ready for the next start.
  always_comb begin
    cnt_nxt_s   = cnt_r;
    div_nxt_s   = div_active_r;
    state_nxt_s = state_r;
    if (!enable_s) begin
      cnt_nxt_s   = '0;
      div_nxt_s   = div_shadow_s;
      state_nxt_s = JS_00;
    end else if (cnt_r >= div_active_r) begin
      cnt_nxt_s   = '0;
      div_nxt_s   = div_shadow_s;
      state_nxt_s = johnson_next(state_r);
    end else begin
      cnt_nxt_s = cnt_r + DIV_W'(1);
    end
  end

  // Sideband selection: Q leads I normally, exchanged when swap is set.
  // Driven from the next state so the outputs line up with the state register.
  always_comb begin
    state_bits_s = state_nxt_s;
    lo_i_nxt_s   = 1'b0;
    lo_q_nxt_s   = 1'b0;
    if (swap_s) begin
      lo_i_nxt_s = state_bits_s[0];
      lo_q_nxt_s = state_bits_s[1];
    end else begin
      lo_i_nxt_s = state_bits_s[1];
      lo_q_nxt_s = state_bits_s[0];
    end
  end

  // Divider, Johnson state and registered LO outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r        <= '0;
      div_active_r <= DIV_W'(DIV_RESET);
      state_r      <= JS_00;
      lo_i_r       <= 1'b0;
      lo_q_r       <= 1'b0;
    end else begin
      cnt_r        <= cnt_nxt_s;
      div_active_r <= div_nxt_s;
      state_r      <= state_nxt_s;
      lo_i_r       <= lo_i_nxt_s;
      lo_q_r       <= lo_q_nxt_s;
    end
  end

  assign lo_i  = lo_i_r;
  assign lo_q  = lo_q_r;
  assign lo_en = enable_s;

endmodule
